spi_peripheral: RTL and testbench
=================================

// Module: spi_peripheral
// PURPOSE
//   SPI (mode 0) write-only register bank feeding pwm_peripheral. Samples host SCLK/COPI/nCS
//   (ui_in[0]/ui_in[1]/ui_in[2]) into the clk domain and decodes 16-bit frames.
//   Holds the five control registers: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
//   en_reg_pwm_15_8 and pwm_duty_cycle.
// PARAMETERS
//   SYNC_STAGES  2   flops per input synchronizer chain (>=2)
//   NUM_REGS     5   implemented addresses 0..NUM_REGS-1; higher addresses ignored
//   FRAME_BITS   16  bits per valid frame: 1 R/W + 7 address + 8 data
// PORTS
//   clk              in   1  system clock; sole clock of the block
//   rst_n            in   1  synchronous active-low reset
//   sclk             in   1  async SPI clock from host (CPOL=0)
//   copi             in   1  async SPI data from host, MSB first
//   ncs              in   1  async SPI chip select, active low
//   en_reg_out_7_0   out  8  addr 0x00: output enable, outputs 7..0
//   en_reg_out_15_8  out  8  addr 0x01: output enable, outputs 15..8
//   en_reg_pwm_7_0   out  8  addr 0x02: PWM select, outputs 7..0
//   en_reg_pwm_15_8  out  8  addr 0x03: PWM select, outputs 15..8
//   pwm_duty_cycle   out  8  addr 0x04: duty cycle (0x00 = 0%, 0xFF = always high)
//   frame_done       out  1  one-clk pulse at every frame end (valid or discarded)
// BEHAVIOUR
// - Clocking and reset:
//   - One clock (clk). rst_n is synchronous, active-low, sampled on clk rising edge.
//   - Reset values: all five registers 0x00, frame_done 0.
//   - Reset values of sync chains: ncs=1, sclk=0, copi=0. State=IDLE, bit count 0, shift reg 0.
// - Input conditioning:
//   - Each input passes through SYNC_STAGES flops, then one "prev" flop.
//   - Edges are detected between the last sync stage and the prev flop.
//   - Host must hold SCLK high and low for >=2 clk periods each.
//     Sampling of COPI stays aligned because all three inputs have the same latency.
// - FSM states:
//   - IDLE -> SHIFT on synced ncs falling edge. Clears bit count and shift reg.
//   - SHIFT: on each synced sclk rising edge:
//     - shift_reg <= {shift_reg[14:0], copi_sync}.
//     - bit count increments, saturating at FRAME_BITS+1 (the overflow marker).
//     sclk falling edges are ignored.
//   - SHIFT -> COMMIT on synced ncs rising edge.
//     If an sclk rising edge is detected in the same cycle, that bit is dropped.
//   - COMMIT (exactly 1 cycle), then -> IDLE. Writes only if all of:
//     - count==FRAME_BITS,
//     - shift_reg[15]==1 (write),
//     - shift_reg[14:8] < NUM_REGS.
//     Data written = shift_reg[7:0]. frame_done=1 in this cycle regardless of validity.
// - Discarded frames (registers unchanged):
//   - fewer than 16 bits, more than 16 bits, R/W=0 (reads unsupported),
//   - address >= NUM_REGS (e.g. 0x05..0x7F).
// - Activity outside a frame:
//   - sclk/copi toggling while in IDLE is ignored.
//   - An ncs rise while in IDLE is ignored.
// - Latency: the register value becomes visible SYNC_STAGES+2 clk edges after the first
//   clk edge that samples ncs high.
// - Register stability:
//   - Registers hold their value between frames. Only one register changes per frame.
//   - The pwm_peripheral may read the registers at any time; they never glitch mid-frame.
// - Reset mid-frame:
//   - Partial frame is lost and all registers return to 0x00.
//   - If ncs is still low when rst_n releases, the synced falling edge starts a SHIFT.
//     Such a frame is discarded unless exactly 16 bits follow.
// STRUCTURE
// - Package spi_reg_pkg:
//   - address localparams ADDR_EN_OUT_LO=7'h00 .. ADDR_DUTY=7'h04,
//   - FRAME_BITS, count width,
//   - FSM state encoding {IDLE, SHIFT, COMMIT}.
// - Sub-module spi_sync_edge: one instance per input. Contains the SYNC_STAGES chain and
//   the prev flop. Outputs level, rise and fall.
// - Top: FSM, shift register, saturating bit counter and the register file.
// TESTING
// - Reset + idle: after reset, all regs = 0x00 and frame_done = 0. Toggle sclk with
//   ncs=1 -> no change.
// - Writes to every address:
//   - 0x80 0xF0 -> en_reg_out_7_0=0xF0.
//   - 0x84 0x80 -> pwm_duty_cycle=0x80.
//   - Check other regs unchanged. Check frame_done pulses once per frame.
// - Discarded frames (each -> no register change, frame_done still pulses):
//   - read 0x00 0xAA,
//   - invalid address 0x85 0x55,
//   - 15-bit frame,
//   - 17-bit frame.
// - Back-to-back frames with 2-clk ncs high gap: 0x82 0x0F then 0x83 0xF0 ->
//   en_reg_pwm_7_0=0x0F and en_reg_pwm_15_8=0xF0.
// - Reset mid-frame: assert rst_n low after 8 bits of 0x81 0xFF.
//   - Regs return to 0x00.
//   - After release, a full frame 0x81 0x3C -> en_reg_out_15_8=0x3C.
// - Timing corner: SCLK at min 2-clk high/low with random clk phase offsets.
//   Check latency SYNC_STAGES+2 and correct data.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants, frame layout and FSM encoding for the SPI register bank.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // One received frame, MSB first on the wire.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer chain plus a history flop; reports the synced level and its edges.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o  = sync_q[STAGES-1];
  assign rise_c_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_c_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register bank: decodes 16-bit frames into five control registers.
module spi_peripheral
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_done
);

  logic sclk_lvl, sclk_rise_c, sclk_fall_c;
  logic copi_lvl, copi_rise_c, copi_fall_c;
  logic ncs_lvl, ncs_rise_c, ncs_fall_c;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(sclk),
    .level_o(sclk_lvl), .rise_c_o(sclk_rise_c), .fall_c_o(sclk_fall_c)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_i(copi),
    .level_o(copi_lvl), .rise_c_o(copi_rise_c), .fall_c_o(copi_fall_c)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_i(ncs),
    .level_o(ncs_lvl), .rise_c_o(ncs_rise_c), .fall_c_o(ncs_fall_c)
  );

  logic unused_c;
  assign unused_c = &{1'b0, sclk_lvl, sclk_fall_c, copi_rise_c, copi_fall_c, ncs_lvl};

  state_e state_q, state_d;
  logic   clear_c, shift_c, commit_c;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (ncs_fall_c) state_d = ST_SHIFT;
      ST_SHIFT:  if (ncs_rise_c) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // A bit whose sclk edge coincides with the ncs release is dropped.
  always_comb begin
    clear_c  = 1'b0;
    shift_c  = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE:   clear_c  = ncs_fall_c;
      ST_SHIFT:  shift_c  = sclk_rise_c & ~ncs_rise_c;
      ST_COMMIT: commit_c = 1'b1;
      default:   ;
    endcase
  end

  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
  logic [DATA_W-1:0]     out_lo_d, out_hi_d, pwm_lo_d, pwm_hi_d, duty_d;
  logic                  frame_done_q, frame_done_d;
  frame_t                frame_c;
  logic                  write_c;

  assign frame_c = frame_t'(shift_q);
  assign write_c = commit_c && (cnt_q == CNT_W'(FRAME_BITS)) && frame_c.wr &&
                   (32'(frame_c.addr) < NUM_REGS);

  // Counter saturates one past a full frame so over-length frames stay invalid.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_c) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_c) begin
      shift_d = {shift_q[FRAME_BITS-2:0], copi_lvl};
      if (cnt_q != CNT_W'(FRAME_BITS + 1)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    out_lo_d     = out_lo_q;
    out_hi_d     = out_hi_q;
    pwm_lo_d     = pwm_lo_q;
    pwm_hi_d     = pwm_hi_q;
    duty_d       = duty_q;
    frame_done_d = (state_d == ST_COMMIT);
    if (write_c) begin
      case (frame_c.addr)
        ADDR_EN_OUT_LO: out_lo_d = frame_c.data;
        ADDR_EN_OUT_HI: out_hi_d = frame_c.data;
        ADDR_EN_PWM_LO: pwm_lo_d = frame_c.data;
        ADDR_EN_PWM_HI: pwm_hi_d = frame_c.data;
        ADDR_DUTY:      duty_d   = frame_c.data;
        default:        ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q      <= '0;
      cnt_q        <= '0;
      out_lo_q     <= '0;
      out_hi_q     <= '0;
      pwm_lo_q     <= '0;
      pwm_hi_q     <= '0;
      duty_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      out_lo_q     <= out_lo_d;
      out_hi_q     <= out_hi_d;
      pwm_lo_q     <= pwm_lo_d;
      pwm_hi_q     <= pwm_hi_d;
      duty_q       <= duty_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a register-bank model feeds a scoreboard checked at each frame end.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       frame_done;

  spi_peripheral #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          pulses = 0;
  int          frames_sent = 0;
  logic [7:0]  m [5];
  logic [39:0] exp_q [$];

  function automatic logic [39:0] dut_snap();
    return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
  endfunction

  function automatic logic [39:0] model_snap();
    return {m[0], m[1], m[2], m[3], m[4]};
  endfunction

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: only a 16-bit write frame to address 0..4 updates one register.
  task automatic model_frame(input logic [31:0] val, input int n);
    logic [6:0] addr;
    addr = val[14:8];
    if (n == 16 && val[15] && addr < 7'd5) m[addr] = val[7:0];
    exp_q.push_back(model_snap());
    frames_sent++;
  endtask

  task automatic clks(input int n, input bit jit);
    repeat (n) @(posedge clk);
    if (jit) #($urandom_range(1, 9));
    else     #1;
  endtask

  task automatic frame_bits(input logic [31:0] val, input int n, input int ph, input bit jit);
    for (int i = n - 1; i >= 0; i--) begin
      copi = val[i];
      clks(ph, jit);
      sclk = 1'b1;
      clks(ph, jit);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] val, input int n, input int ph, input bit jit,
                            input int gap);
    ncs = 1'b0;
    clks(3, jit);
    frame_bits(val, n, ph, jit);
    clks(3, jit);
    model_frame(val, n);
    ncs  = 1'b1;
    copi = 1'b0;
    clks(gap, 1'b0);
  endtask

  // Scoreboard: each frame_done pulse pops the snapshot expected once the commit lands.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && frame_done === 1'b1) begin
      pulses++;
      @(negedge clk);
      check("frame_done_single", 40'(frame_done), 40'd0);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_frame", 40'(pulses), 40'd0);
      end else begin
        check($sformatf("sb_frame%0d", pulses), dut_snap(), exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] old_duty;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    clks(5, 1'b0);
    check("reset_regs", dut_snap(), 40'h0);
    check("reset_frame_done", 40'(frame_done), 40'd0);
    rst_n = 1'b1;
    clks(3, 1'b0);

    // sclk/copi activity with ncs high must be ignored.
    for (int i = 0; i < 10; i++) begin
      sclk = 1'b1; copi = ~copi; clks(2, 1'b0);
      sclk = 1'b0; clks(2, 1'b0);
    end
    copi = 1'b0;
    clks(4, 1'b0);
    check("idle_regs", dut_snap(), 40'h0);
    check("idle_no_pulse", 40'(pulses), 40'd0);

    send_frame(32'h80F0, 16, 3, 1'b0, 6);
    send_frame(32'h8133, 16, 3, 1'b0, 6);
    send_frame(32'h820C, 16, 3, 1'b0, 6);
    send_frame(32'h83C0, 16, 3, 1'b0, 6);
    send_frame(32'h8480, 16, 3, 1'b0, 6);
    check("all_addr_regs", dut_snap(), 40'hF0_33_0C_C0_80);

    send_frame(32'h00AA, 16, 3, 1'b0, 6);
    send_frame(32'h8555, 16, 3, 1'b0, 6);
    send_frame(32'h7F11, 15, 3, 1'b0, 6);
    send_frame(32'h1_8122, 17, 3, 1'b0, 6);
    check("discard_regs", dut_snap(), 40'hF0_33_0C_C0_80);

    send_frame(32'h820F, 16, 2, 1'b0, 2);
    send_frame(32'h83F0, 16, 2, 1'b0, 6);
    check("b2b_regs", dut_snap(), 40'hF0_33_0F_F0_80);

    // Reset part-way through a frame.
    ncs = 1'b0;
    clks(3, 1'b0);
    frame_bits(32'h81, 8, 2, 1'b0);
    rst_n = 1'b0;
    clks(3, 1'b0);
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    check("rst_mid_regs", dut_snap(), 40'h0);
    ncs = 1'b1; copi = 1'b0;
    clks(3, 1'b0);
    rst_n = 1'b1;
    clks(4, 1'b0);
    send_frame(32'h813C, 16, 2, 1'b0, 6);
    check("post_rst_regs", dut_snap(), 40'h00_3C_00_00_00);

    // Minimum sclk phases with random sub-cycle offsets, plus exact commit latency.
    old_duty = m[4];
    ncs = 1'b0;
    clks(3, 1'b1);
    frame_bits(32'h84A5, 16, 2, 1'b1);
    clks(3, 1'b1);
    model_frame(32'h84A5, 16);
    ncs = 1'b1;
    copi = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("lat_before", 40'(pwm_duty_cycle), 40'(old_duty));
    check("lat_frame_done", 40'(frame_done), 40'd1);
    @(posedge clk);
    #1;
    check("lat_after", 40'(pwm_duty_cycle), 40'h0A5);
    clks(6, 1'b0);

    for (int k = 0; k < 3; k++) begin
      logic [31:0] v;
      v = {16'h0, 1'b1, 7'(k + 1), 8'($urandom_range(0, 255))};
      send_frame(v, 16, 2, 1'b1, 4);
    end

    clks(10, 1'b0);
    check("sb_drained", 40'(exp_q.size()), 40'd0);
    check("pulse_count", 40'(pulses), 40'(frames_sent));
    check("final_regs", dut_snap(), model_snap());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
